generate_point: RTL and testbench
=================================

Name: generate_point

Overview:
- Pseudo-random food-point generator for a two-player snake game on a 32x32 grid.
- Produces a local random seed for exchange with the opponent board.
- On game start, combines the local seed with the remote seed so that both boards step identical point sequences.
- Emits a new point when the snake head collides with the current point.

Parameters:
- X_POLY, 5'h14, Galois mask for the x LFSR (x^5+x^3+1, maximal length).
- Y_POLY, 5'h12, Galois mask for the y LFSR (x^5+x^2+1, maximal length).
- SYNC_STAGES, 2, number of flops used to synchronise clk_div.

Ports:
- clk_75  in  1  system clock (75 MHz); the only clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- clk_div  in  1  slow game-step strobe; sampled as data and never used as a clock.
- mode  in  game_mode  MENU/GAME state from the top-level FSM.
- local_start  in  1  local player pressed start.
- seed_x_in  in  5  remote player's x seed.
- seed_y_in  in  5  remote player's y seed.
- colision  in  1  snake head currently on the point.
- seed_x_out  out  5  latched local x seed.
- seed_y_out  out  5  latched local y seed.
- seed_rdy  out  1  local seeds valid.
- point_gen_x  out  5  current point x.
- point_gen_y  out  5  current point y.

Behaviour:
- LFSR step function, applied to every LFSR: s' = {1'b0, s[4:1]} ^ (s[0] ? POLY : 5'h0).
  - All registers update on posedge clk_75.
- Tick generation:
  - clk_div passes through a SYNC_STAGES synchroniser, then a rising-edge detect.
  - tick is a 1-cycle pulse per clk_div rising edge, with 3-4 cycle latency.
- Entropy LFSRs ex, ey:
  - Step every clk_75 cycle in every mode.
  - Reset values: ex=5'h01, ey=5'h02.
  - They never reach zero.
- Seed latch:
  - On the cycle where local_start rises (0->1, edge-detected internally): seed_x_out<=ex, seed_y_out<=ey, seed_rdy<=1.
  - seed_rdy and the seed outputs hold while local_start stays 1.
  - When mode==MENU and local_start==0, seed_rdy clears to 0. Seed values are kept.
- Initialisation flag init:
  - Trigger: mode==GAME && seed_rdy && !init.
  - On trigger: px <= seed_x_out ^ seed_x_in, py <= seed_y_out ^ seed_y_in; any zero result is replaced by 5'h1F; then init<=1.
  - The point appears on the outputs in the following cycle.
- Point advance:
  - Condition: mode==GAME && init && tick && colision.
  - Action: px and py each step once.
  - A colision held across N ticks gives N steps; a colision with no tick gives no step.
- Return to menu: when mode==MENU, init<=0 and px/py hold their values.
  - A later GAME entry re-initialises from the current seeds, even when local_start stayed 0, as long as seed_rdy==1.
  - With seed_rdy==0 the GAME entry does nothing.
- Simultaneous events: if init trigger and point advance occur in the same cycle, init has priority.
- Outputs: point_gen_x=px and point_gen_y=py, registered.
  - Values stay in 1..31 after init and never reach zero.
- Reset values: seed_x_out=0, seed_y_out=0, seed_rdy=0, px=0, py=0, init=0, synchroniser=0.
  - Reset mid-game aborts immediately, asynchronously.

Optional Feature:
- Macro: GENERATE_POINT_FIXED_SEED_EN.
- Defined: the entropy LFSRs are replaced by constants ex=5'h15, ey=5'h0A. The seed latch captures these constants, giving a reproducible sequence for lab debug.
- Undefined: free-running entropy LFSRs as described above.

Decomposition:
- snake_pkg holds:
  - game_mode enum (MENU, GAME, ...).
  - GRID_BITS=5.
  - Default POLY masks.
- One natural sub-module, lfsr5_step, holds the combinational step function with a POLY parameter. It is instantiated four times.
- The synchroniser and edge detect stay inline.

Test Plan:
- Reset: rst=0 for 10 cycles -> all outputs 0, seed_rdy=0. Release and run 500 cycles in MENU -> point outputs stay 0, seed_rdy=0.
- Start: local_start 0->1, mode=GAME, seed_in=1/1 -> seed_rdy=1 one cycle after the edge; the following cycles give point_gen_x=seed_x_out^1 (or 5'h1F if zero), and point_gen_y likewise.
- Single collision: colision=1 over one clk_div rising edge -> exactly one step. With FIXED_SEED_EN and entry at seed_out 5'h15^1=5'h14, x moves to 5'h0A.
- Held collision: colision=1 across 3 clk_div edges -> exactly 3 steps on each axis; no step between ticks.
- Menu and re-entry: mode=MENU with local_start=0 -> seed_rdy=0, point holds; mode=GAME again -> no re-init, and colision over one tick -> no change.
- Async reset asserted mid-game -> outputs 0 in the same cycle with no clock edge needed.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game datapath.
package snake_pkg;

  localparam int GRID_BITS = 5;

  localparam logic [GRID_BITS-1:0] X_POLY_DEF = 5'h14;
  localparam logic [GRID_BITS-1:0] Y_POLY_DEF = 5'h12;

  localparam logic [GRID_BITS-1:0] FIXED_SEED_X = 5'h15;
  localparam logic [GRID_BITS-1:0] FIXED_SEED_Y = 5'h0A;

  typedef enum logic [1:0] {
    MENU = 2'd0,
    GAME = 2'd1,
    OVER = 2'd2
  } game_mode;

  // An all-zero LFSR state would lock up, so it is mapped to the top corner.
  function automatic logic [GRID_BITS-1:0] nonzero_or_max(input logic [GRID_BITS-1:0] v);
    return (v == '0) ? '1 : v;
  endfunction

endpackage

// File: rtl/lfsr5_step.sv
// One Galois step of a 5-bit LFSR: shift right, fold POLY in when the LSB is set.
module lfsr5_step
  import snake_pkg::*;
#(
  parameter logic [GRID_BITS-1:0] POLY = X_POLY_DEF
) (
  input  logic [GRID_BITS-1:0] state_i,
  output logic [GRID_BITS-1:0] next_o
);

  assign next_o = {1'b0, state_i[GRID_BITS-1:1]} ^ (state_i[0] ? POLY : '0);

endmodule

// File: rtl/generate_point.sv
// Food-point generator: local seed capture, seed exchange init, LFSR point advance.
// Build macro GENERATE_POINT_FIXED_SEED_EN swaps the entropy LFSRs for constants.
module generate_point
  import snake_pkg::*;
#(
  parameter logic [GRID_BITS-1:0] X_POLY      = X_POLY_DEF,
  parameter logic [GRID_BITS-1:0] Y_POLY      = Y_POLY_DEF,
  parameter int                   SYNC_STAGES = 2
) (
  input  logic                 clk_75,
  input  logic                 rst,
  input  logic                 clk_div,
  input  game_mode             mode,
  input  logic                 local_start,
  input  logic [GRID_BITS-1:0] seed_x_in,
  input  logic [GRID_BITS-1:0] seed_y_in,
  input  logic                 colision,
  output logic [GRID_BITS-1:0] seed_x_out,
  output logic [GRID_BITS-1:0] seed_y_out,
  output logic                 seed_rdy,
  output logic [GRID_BITS-1:0] point_gen_x,
  output logic [GRID_BITS-1:0] point_gen_y
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   div_prev_q;
  logic                   start_prev_q;
  logic                   tick;
  logic                   start_rise;

  logic [GRID_BITS-1:0] ex_cur, ey_cur;
  logic [GRID_BITS-1:0] seed_x_q, seed_x_d, seed_y_q, seed_y_d;
  logic                 seed_rdy_q, seed_rdy_d;
  logic [GRID_BITS-1:0] px_q, px_d, py_q, py_d;
  logic [GRID_BITS-1:0] px_step, py_step;
  logic                 init_q, init_d;

  assign tick       = sync_q[SYNC_STAGES-1] & ~div_prev_q;
  assign start_rise = local_start & ~start_prev_q;

`ifdef GENERATE_POINT_FIXED_SEED_EN
  assign ex_cur = FIXED_SEED_X;
  assign ey_cur = FIXED_SEED_Y;
`else
  logic [GRID_BITS-1:0] ex_q, ey_q, ex_step, ey_step;

  lfsr5_step #(.POLY(X_POLY)) u_ex_step (.state_i(ex_q), .next_o(ex_step));
  lfsr5_step #(.POLY(Y_POLY)) u_ey_step (.state_i(ey_q), .next_o(ey_step));

  // Free-running entropy: the press time of local_start picks the seed.
  always_ff @(posedge clk_75 or negedge rst) begin
    if (!rst) begin
      ex_q <= 5'h01;
      ey_q <= 5'h02;
    end else begin
      ex_q <= ex_step;
      ey_q <= ey_step;
    end
  end

  assign ex_cur = ex_q;
  assign ey_cur = ey_q;
`endif

  lfsr5_step #(.POLY(X_POLY)) u_px_step (.state_i(px_q), .next_o(px_step));
  lfsr5_step #(.POLY(Y_POLY)) u_py_step (.state_i(py_q), .next_o(py_step));

  always_comb begin
    seed_x_d   = seed_x_q;
    seed_y_d   = seed_y_q;
    seed_rdy_d = seed_rdy_q;
    if (start_rise) begin
      seed_x_d   = ex_cur;
      seed_y_d   = ey_cur;
      seed_rdy_d = 1'b1;
    end else if (mode == MENU && !local_start) begin
      seed_rdy_d = 1'b0;
    end
  end

  // Init wins over advance so both boards start from the same combined seed.
  always_comb begin
    px_d   = px_q;
    py_d   = py_q;
    init_d = init_q;
    if (mode == MENU) begin
      init_d = 1'b0;
    end else if (mode == GAME) begin
      if (seed_rdy_q && !init_q) begin
        px_d   = nonzero_or_max(seed_x_q ^ seed_x_in);
        py_d   = nonzero_or_max(seed_y_q ^ seed_y_in);
        init_d = 1'b1;
      end else if (init_q && tick && colision) begin
        px_d = px_step;
        py_d = py_step;
      end
    end
  end

  always_ff @(posedge clk_75 or negedge rst) begin
    if (!rst) begin
      sync_q       <= '0;
      div_prev_q   <= 1'b0;
      start_prev_q <= 1'b0;
      seed_x_q     <= '0;
      seed_y_q     <= '0;
      seed_rdy_q   <= 1'b0;
      px_q         <= '0;
      py_q         <= '0;
      init_q       <= 1'b0;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], clk_div};
      div_prev_q   <= sync_q[SYNC_STAGES-1];
      start_prev_q <= local_start;
      seed_x_q     <= seed_x_d;
      seed_y_q     <= seed_y_d;
      seed_rdy_q   <= seed_rdy_d;
      px_q         <= px_d;
      py_q         <= py_d;
      init_q       <= init_d;
    end
  end

  assign seed_x_out  = seed_x_q;
  assign seed_y_out  = seed_y_q;
  assign seed_rdy    = seed_rdy_q;
  assign point_gen_x = px_q;
  assign point_gen_y = py_q;

endmodule

// File: tb/tb_generate_point.sv
// Directed + randomized bench for generate_point against a step-count reference model.
module tb_generate_point;
  import snake_pkg::*;

  logic       clk_75 = 1'b0;
  logic       rst;
  logic       clk_div;
  game_mode   mode;
  logic       local_start;
  logic [4:0] seed_x_in, seed_y_in;
  logic       colision;
  logic [4:0] seed_x_out, seed_y_out;
  logic       seed_rdy;
  logic [4:0] point_gen_x, point_gen_y;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  generate_point dut (
    .clk_75     (clk_75),
    .rst        (rst),
    .clk_div    (clk_div),
    .mode       (mode),
    .local_start(local_start),
    .seed_x_in  (seed_x_in),
    .seed_y_in  (seed_y_in),
    .colision   (colision),
    .seed_x_out (seed_x_out),
    .seed_y_out (seed_y_out),
    .seed_rdy   (seed_rdy),
    .point_gen_x(point_gen_x),
    .point_gen_y(point_gen_y)
  );

  always #5 clk_75 = ~clk_75;

  // Clock edges since reset release = number of entropy LFSR steps taken.
  always @(posedge clk_75 or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  function automatic logic [4:0] lstep(input logic [4:0] s, input logic [4:0] poly);
    return {1'b0, s[4:1]} ^ (s[0] ? poly : 5'h00);
  endfunction

  function automatic logic [4:0] lsteps(input logic [4:0] s, input logic [4:0] poly, input int n);
    logic [4:0] v;
    v = s;
    for (int i = 0; i < n; i++) v = lstep(v, poly);
    return v;
  endfunction

  function automatic logic [4:0] nz(input logic [4:0] v);
    return (v == 5'h00) ? 5'h1F : v;
  endfunction

  function automatic logic [4:0] seed_x_model(input int n);
`ifdef GENERATE_POINT_FIXED_SEED_EN
    return 5'h15;
`else
    return lsteps(5'h01, 5'h14, n);
`endif
  endfunction

  function automatic logic [4:0] seed_y_model(input int n);
`ifdef GENERATE_POINT_FIXED_SEED_EN
    return 5'h0A;
`else
    return lsteps(5'h02, 5'h12, n);
`endif
  endfunction

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_75);
  endtask

  task automatic pulse();
    clk_div = 1'b1;
    cycles(4);
    clk_div = 1'b0;
    cycles(4);
  endtask

  logic [4:0] sx, sy, ex_px, ex_py;
  int         n, np;
  logic       col;

  initial begin
    rst = 1'b0; clk_div = 1'b0; mode = MENU; local_start = 1'b0;
    seed_x_in = 5'h00; seed_y_in = 5'h00; colision = 1'b0;
    cycles(10);
    check("rst_px", point_gen_x, 5'h00);
    check("rst_py", point_gen_y, 5'h00);
    check("rst_sx", seed_x_out, 5'h00);
    check("rst_sy", seed_y_out, 5'h00);
    check("rst_rdy", {4'h0, seed_rdy}, 5'h00);

    rst = 1'b1;
    cycles(500);
    check("menu_px", point_gen_x, 5'h00);
    check("menu_py", point_gen_y, 5'h00);
    check("menu_rdy", {4'h0, seed_rdy}, 5'h00);

    // Start: seeds latch at the next edge, point one edge later.
    n = cyc;
    local_start = 1'b1; mode = GAME; seed_x_in = 5'h01; seed_y_in = 5'h01;
    sx = seed_x_model(n); sy = seed_y_model(n);
    cycles(1);
    check("start_rdy", {4'h0, seed_rdy}, 5'h01);
    check("start_sx", seed_x_out, sx);
    check("start_sy", seed_y_out, sy);
    check("start_px_pre", point_gen_x, 5'h00);
    cycles(1);
    ex_px = nz(sx ^ 5'h01); ex_py = nz(sy ^ 5'h01);
    check("init_px", point_gen_x, ex_px);
    check("init_py", point_gen_y, ex_py);
`ifdef GENERATE_POINT_FIXED_SEED_EN
    check("fixed_init_px", point_gen_x, 5'h14);
`endif

    // Randomized collision windows over 1..3 clk_div edges.
    for (int r = 0; r < 8; r++) begin
      col = (r == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      np  = (r == 0) ? 1 : int'($urandom_range(1, 3));
      colision = col;
      cycles(2);
      for (int p = 0; p < np; p++) begin
        pulse();
        if (col) begin
          ex_px = lstep(ex_px, 5'h14);
          ex_py = lstep(ex_py, 5'h12);
        end
        check("adv_px", point_gen_x, ex_px);
        check("adv_py", point_gen_y, ex_py);
      end
      colision = 1'b0;
      cycles(2);
    end
`ifdef GENERATE_POINT_FIXED_SEED_EN
    check("fixed_first_step", lstep(5'h14, 5'h14), 5'h0A);
`endif

    // Collision with no tick never moves the point.
    colision = 1'b1;
    cycles(20);
    colision = 1'b0;
    check("notick_px", point_gen_x, ex_px);
    check("notick_py", point_gen_y, ex_py);

    // Menu with start released: seed_rdy drops, point and seeds hold.
    mode = MENU; local_start = 1'b0;
    cycles(2);
    check("menu2_rdy", {4'h0, seed_rdy}, 5'h00);
    check("menu2_px", point_gen_x, ex_px);
    check("menu2_sx", seed_x_out, sx);
    mode = GAME;
    colision = 1'b1;
    cycles(2);
    pulse();
    colision = 1'b0;
    check("noinit_px", point_gen_x, ex_px);
    check("noinit_py", point_gen_y, ex_py);

    // New start in MENU, then GAME with remote seed equal to local -> zero -> 1F.
    mode = MENU;
    cycles(3);
    n = cyc;
    local_start = 1'b1;
    sx = seed_x_model(n); sy = seed_y_model(n);
    cycles(1);
    check("restart_rdy", {4'h0, seed_rdy}, 5'h01);
    check("restart_sx", seed_x_out, sx);
    check("restart_sy", seed_y_out, sy);
    seed_x_in = sx; seed_y_in = sy; mode = GAME;
    cycles(2);
    check("zero_px", point_gen_x, 5'h1F);
    check("zero_py", point_gen_y, 5'h1F);
    colision = 1'b1;
    cycles(2);
    pulse();
    colision = 1'b0;
    check("from1f_px", point_gen_x, lstep(5'h1F, 5'h14));
    check("from1f_py", point_gen_y, lstep(5'h1F, 5'h12));

    // Back to MENU with start held: seed_rdy stays, GAME re-inits with new remote seed.
    mode = MENU;
    cycles(3);
    check("hold_rdy", {4'h0, seed_rdy}, 5'h01);
    seed_x_in = 5'($urandom_range(0, 31)); seed_y_in = 5'($urandom_range(0, 31));
    mode = GAME;
    cycles(2);
    check("reinit_px", point_gen_x, nz(sx ^ seed_x_in));
    check("reinit_py", point_gen_y, nz(sy ^ seed_y_in));

    // Asynchronous reset mid-cycle, checked before the next clock edge.
    #2 rst = 1'b0;
    #1;
    check("arst_px", point_gen_x, 5'h00);
    check("arst_py", point_gen_y, 5'h00);
    check("arst_sx", seed_x_out, 5'h00);
    check("arst_rdy", {4'h0, seed_rdy}, 5'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
